uart_cmd_host: RTL
==================

// Module: uart_cmd_host
// PURPOSE
//  Host-side initiator for the UART command link served by the board controller. On start it
//  transmits the command byte then one operand byte (8N1), then receives RESP_BYTES reply bytes
//  and assembles them into a result word. Sits on the PC/test-harness FPGA side; its tx drives
//  the board's rx line, its rx listens to the board's tx line.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock in Hz
//  BAUD         9600        line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (5208 at defaults)
//  CMD_BYTE     8'h73       command opcode sent first ('s')
//  RESP_BYTES   3           reply byte count; result width = 8*RESP_BYTES (24)
//  RESP_TIMEOUT 200         bit periods allowed from end of operand stop bit to reply done
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  start        in   1   one-cycle request; accepted only when busy=0
//  operand      in   8   operand byte, captured on accepted start
//  busy         out  1   high from cycle after accepted start until done/error pulse
//  tx           out  1   serial out to board rx, idle high
//  rx           in   1   serial in from board tx, asynchronous
//  result       out  24  assembled reply, first received byte = MSB
//  done         out  1   one-cycle pulse, result valid and held until next accepted start
//  err_frame    out  1   one-cycle pulse: reply stop bit sampled low
//  err_timeout  out  1   one-cycle pulse: reply not complete within RESP_TIMEOUT
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, tx=1, busy=0, result=0, done=0, err_*=0, counters 0.
//  - FSM: IDLE -> SEND_CMD -> SEND_OP -> WAIT_RESP -> RECV -> (DONE | ERR) -> IDLE.
//  - IDLE: start=1 latches operand, busy=1 next cycle; start while busy ignored (no queueing).
//  - Serializer: start bit 0, data LSB first, stop bit 1, each exactly CLKS_PER_BIT clocks.
//    tx falls on the cycle after start accepted; cmd stop bit followed directly by operand start
//    bit (no gap). Total send time 20*CLKS_PER_BIT clocks.
//  - rx: 2-FF synchroniser; receive logic active only in WAIT_RESP/RECV (bytes arriving in
//    IDLE/SEND_* are discarded). Falling edge arms receiver; re-sample at CLKS_PER_BIT/2:
//    high -> glitch, return to hunting; low -> sample 8 data bits at mid-bit, then stop bit.
//  - Each byte shifts in: result_sh <= {result_sh[15:0], byte}. After RESP_BYTES good bytes,
//    result <= result_sh and done pulses on the same cycle; busy drops that cycle.
//  - Stop bit low: err_frame pulse, result unchanged, back to IDLE (rest of reply ignored).
//  - Timeout counter (bit-period granularity) starts at end of operand stop bit; reaching
//    RESP_TIMEOUT before the last stop bit: err_timeout pulse, back to IDLE. If last stop bit
//    and timeout coincide, done wins.
//  - done, err_frame, err_timeout mutually exclusive; each asserts at most once per transaction.
//  - Reset mid-transaction: immediate abort, tx forced high, outputs to reset values.
//  - Baud counter width = $clog2(CLKS_PER_BIT); bit counter wraps 0..9 per frame.
// CONFIGURATION
//  UART_HOST_TIMEOUT_EN defined: timeout counter and err_timeout as above.
//  Not defined: no timeout logic; WAIT_RESP waits indefinitely (only rst or reply exits);
//  err_timeout tied 0.
// TESTING (50 MHz clk, 9600 baud, bench UART model on rx, 104160 ns/bit)
//  1 start, operand=8'h03 -> tx frames 0x73 then 0x03 LSB-first, each bit 5208 clks +-0;
//    model replies 00 00 2A -> result=24'h00002A, done one pulse, busy low same cycle.
//  2 reply 12 34 56 -> result=24'h123456 (MSB first); second start operand=8'h01 -> tx 0x73,0x01.
//  3 start pulsed again during SEND_OP -> ignored, frames unchanged, single done.
//  4 reply byte 2 with stop bit 0 -> err_frame pulse, result keeps previous 24'h123456, IDLE.
//  5 no reply (TIMEOUT_EN) -> err_timeout exactly 200 bit periods after operand stop; without
//    macro -> busy stays 1; 1-bit-width/4 low glitch on rx in WAIT_RESP -> no byte counted.
//  6 rst low mid operand frame -> tx=1, busy=0 within reset; fresh start works normally.

Source files
------------

// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: sends CMD_BYTE + operand, then collects a RESP_BYTES reply.
// Define UART_HOST_TIMEOUT_EN to enable the reply timeout and err_timeout.
module uart_cmd_host #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 9600,
  parameter logic [7:0] CMD_BYTE     = 8'h73,
  parameter int         RESP_BYTES   = 3,
  parameter int         RESP_TIMEOUT = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              operand,
  output logic                    busy,
  output logic                    tx,
  input  logic                    rx,
  output logic [8*RESP_BYTES-1:0] result,
  output logic                    done,
  output logic                    err_frame,
  output logic                    err_timeout
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(CPB);
  localparam int RW  = 8 * RESP_BYTES;
  localparam int CW  = $clog2(RESP_BYTES + 1);

  localparam logic [BW-1:0] B_LAST = BW'(CPB - 1);
  localparam logic [BW-1:0] B_HALF = BW'(CPB / 2 - 1);
  localparam logic [CW-1:0] N_LAST = CW'(RESP_BYTES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RECV = 3'd4;

  logic [2:0]    r_state;
  logic [9:0]    r_sh;
  logic [7:0]    r_op;
  logic [BW-1:0] r_bcnt;
  logic [3:0]    r_bit;
  logic          r_rx1, r_rx2, r_rx3;
  logic [7:0]    r_rbyte;
  logic [RW-9:0] r_rsh;
  logic [CW-1:0] r_nbytes;
  logic [RW-1:0] r_result;
  logic          r_busy, r_done, r_err_fr, r_err_to;
  logic          w_tmo;
  logic          w_fall;

  assign tx          = r_sh[0];
  assign busy        = r_busy;
  assign result      = r_result;
  assign done        = r_done;
  assign err_frame   = r_err_fr;
  assign err_timeout = r_err_to;
  assign w_fall      = r_rx3 & ~r_rx2;

`ifdef UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  logic [BW-1:0] r_tclk;
  logic [TW-1:0] r_tbits;
  logic          w_listen;
  logic          w_fin;

  assign w_listen = (r_state == S_WAIT) || (r_state == S_RECV);
  assign w_tmo    = w_listen && (r_tclk == B_LAST) &&
                    (r_tbits == TW'(RESP_TIMEOUT - 1));
  // last good stop bit beats a coincident timeout
  assign w_fin    = (r_state == S_RECV) && (r_bit == 4'd9) &&
                    (r_bcnt == B_LAST) && r_rx2 && (r_nbytes == N_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tclk  <= '0;
      r_tbits <= '0;
    end else if (!w_listen) begin
      r_tclk  <= '0;
      r_tbits <= '0;
    end else if (r_tclk == B_LAST) begin
      r_tclk  <= '0;
      r_tbits <= r_tbits + 1'b1;
    end else begin
      r_tclk  <= r_tclk + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx1 <= 1'b1;
      r_rx2 <= 1'b1;
      r_rx3 <= 1'b1;
    end else begin
      r_rx1 <= rx;
      r_rx2 <= r_rx1;
      r_rx3 <= r_rx2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_sh     <= '1;
      r_op     <= '0;
      r_bcnt   <= '0;
      r_bit    <= '0;
      r_rbyte  <= '0;
      r_rsh    <= '0;
      r_nbytes <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err_fr <= 1'b0;
      r_err_to <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err_fr <= 1'b0;
      r_err_to <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= operand;
            r_sh     <= {1'b1, CMD_BYTE, 1'b0};
            r_bcnt   <= '0;
            r_bit    <= '0;
            r_nbytes <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CMD;
          end
        end
        S_CMD, S_OP: begin
          if (r_bcnt != B_LAST) begin
            r_bcnt <= r_bcnt + 1'b1;
          end else begin
            r_bcnt <= '0;
            if (r_bit != 4'd9) begin
              r_bit <= r_bit + 4'd1;
              r_sh  <= {1'b1, r_sh[9:1]};
            end else begin
              r_bit <= '0;
              if (r_state == S_CMD) begin
                r_sh    <= {1'b1, r_op, 1'b0};
                r_state <= S_OP;
              end else begin
                r_sh    <= '1;
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (w_fall) begin
            r_bcnt  <= '0;
            r_bit   <= '0;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (r_bit == 4'd0) begin
            if (r_bcnt != B_HALF) begin
              r_bcnt <= r_bcnt + 1'b1;
            end else begin
              r_bcnt <= '0;
              if (r_rx2) r_state <= S_WAIT;
              else       r_bit   <= 4'd1;
            end
          end else if (r_bcnt != B_LAST) begin
            r_bcnt <= r_bcnt + 1'b1;
          end else begin
            r_bcnt <= '0;
            if (r_bit != 4'd9) begin
              r_rbyte <= {r_rx2, r_rbyte[7:1]};
              r_bit   <= r_bit + 4'd1;
            end else begin
              r_bit <= '0;
              if (!r_rx2) begin
                r_err_fr <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= S_IDLE;
              end else if (r_nbytes == N_LAST) begin
                r_result <= {r_rsh, r_rbyte};
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= S_IDLE;
              end else begin
                r_rsh    <= {r_rsh[RW-17:0], r_rbyte};
                r_nbytes <= r_nbytes + 1'b1;
                r_state  <= S_WAIT;
              end
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
`ifdef UART_HOST_TIMEOUT_EN
      if (w_tmo && !w_fin) begin
        r_err_to <= 1'b1;
        r_err_fr <= 1'b0;
        r_done   <= 1'b0;
        r_busy   <= 1'b0;
        r_state  <= S_IDLE;
      end
`endif
    end
  end

endmodule
